// File: rtl/vga_pkg.sv
// Shared timing constants and RGB565 colours for the 640x480@60 raster path.
// Also used by the colour generator.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 16;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam int HA = H_SYNC + H_BACK;
  localparam int VA = V_SYNC + V_BACK;

  localparam logic [RGB_W-1:0] RGB_BLACK  = 16'h0000;
  localparam logic [RGB_W-1:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [RGB_W-1:0] RGB_RED    = 16'hF800;
  localparam logic [RGB_W-1:0] RGB_GREEN  = 16'h07E0;
  localparam logic [RGB_W-1:0] RGB_BLUE   = 16'h001F;
  localparam logic [RGB_W-1:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [RGB_W-1:0] RGB_CYAN   = 16'h07FF;
  localparam logic [RGB_W-1:0] RGB_MAGENT = 16'hF81F;
  localparam logic [RGB_W-1:0] RGB_GRAY   = 16'h8410;

  function automatic logic [RGB_W-1:0] rgb565(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_ctrl.sv
// Raster timing generator: h/v counters, sync decodes, pixel request one
// clock ahead of display, and the registered RGB565 output.
module vga_ctrl #(
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_VALID = vga_pkg::H_VALID,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_VALID = vga_pkg::V_VALID,
  parameter int V_FRONT = vga_pkg::V_FRONT
) (
  input  logic                         vga_clk,
  input  logic                         sys_rst_n,
  input  logic [vga_pkg::RGB_W-1:0]    pix_data,
  output logic [vga_pkg::COORD_W-1:0]  pix_x,
  output logic [vga_pkg::COORD_W-1:0]  pix_y,
  output logic                         pix_data_req,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         rgb_valid,
  output logic [vga_pkg::RGB_W-1:0]    rgb,
  output logic                         frame_start
);
  import vga_pkg::*;

  localparam int CW = COORD_W;

  localparam logic [CW-1:0] L_H_SYNC   = CW'(H_SYNC);
  localparam logic [CW-1:0] L_H_LAST   = CW'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [CW-1:0] L_HA       = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] L_HA_END   = CW'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CW-1:0] L_REQ_LO   = CW'(H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] L_REQ_HI   = CW'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [CW-1:0] L_V_SYNC   = CW'(V_SYNC);
  localparam logic [CW-1:0] L_V_LAST   = CW'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [CW-1:0] L_VA       = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] L_VA_END   = CW'(V_SYNC + V_BACK + V_VALID);

  logic [CW-1:0]    r_cnt_h;
  logic [CW-1:0]    r_cnt_v;
  logic [RGB_W-1:0] r_rgb;

  logic w_h_end;
  logic w_v_end;
  logic w_h_act;
  logic w_h_req;
  logic w_v_act;
  logic w_req;

  assign w_h_end = (r_cnt_h == L_H_LAST);
  assign w_v_end = (r_cnt_v == L_V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else begin
      r_cnt_h <= w_h_end ? '0 : r_cnt_h + 1'b1;
      if (w_h_end) begin
        r_cnt_v <= w_v_end ? '0 : r_cnt_v + 1'b1;
      end
    end
  end

  assign w_h_act = (r_cnt_h >= L_HA)     && (r_cnt_h < L_HA_END);
  assign w_h_req = (r_cnt_h >= L_REQ_LO) && (r_cnt_h < L_REQ_HI);
  assign w_v_act = (r_cnt_v >= L_VA)     && (r_cnt_v < L_VA_END);
  assign w_req   = w_h_req && w_v_act;

  assign hsync        = ~(r_cnt_h < L_H_SYNC);
  assign vsync        = ~(r_cnt_v < L_V_SYNC);
  assign rgb_valid    = w_h_act && w_v_act;
  assign pix_data_req = w_req;
  assign pix_x        = w_req ? r_cnt_h - L_REQ_LO : '1;
  assign pix_y        = w_req ? r_cnt_v - L_VA     : '1;
  assign frame_start  = (r_cnt_h == '0) && (r_cnt_v == '0);

  // Loading black outside the request window keeps rgb at 0 whenever rgb_valid is low.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rgb <= RGB_BLACK;
    end else begin
      r_rgb <= w_req ? pix_data : RGB_BLACK;
    end
  end

  assign rgb = r_rgb;

endmodule
